// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_pkg
// Purpose  : Shared encodings for the two-input gate checker: gate selection
//            codes, checker FSM states and the truth-table vector count.
// Revision : 1.0 - initial release
// ============================================================================
package gate_pkg;

   // Gate type selection codes; 6 and 7 are unused and rejected at start.
   localparam logic [2:0] GATE_AND  = 3'd0;
   localparam logic [2:0] GATE_OR   = 3'd1;
   localparam logic [2:0] GATE_NAND = 3'd2;
   localparam logic [2:0] GATE_NOR  = 3'd3;
   localparam logic [2:0] GATE_XOR  = 3'd4;
   localparam logic [2:0] GATE_XNOR = 3'd5;

   // Checker FSM state encodings.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // A two-input gate has a four-row truth table.
   localparam int NUM_VECTORS = 4;

endpackage : gate_pkg
`default_nettype wire

// File: rtl/gate_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : gate_checker_if
// Purpose  : Control, stimulus and result bundle between the gate checker
//            (slave) and whatever starts sweeps and hosts the gate (master).
// Revision : 1.0 - initial release
// ============================================================================
interface gate_checker_if;
   logic       start;
   logic [2:0] gate_sel;
   logic       a;
   logic       b;
   logic       x;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_cnt;
   logic [3:0] fail_mask;

   // Requester / gate-host side.
   modport master (
      output start, gate_sel, x,
      input  a, b, busy, done, pass, err_cnt, fail_mask
   );

   // Checker side.
   modport slave (
      input  start, gate_sel, x,
      output a, b, busy, done, pass, err_cnt, fail_mask
   );
endinterface : gate_checker_if
`default_nettype wire

// File: rtl/gate_expect.sv
`default_nettype none
// ============================================================================
// Module   : gate_expect
// Purpose  : Combinational reference model of the gate library: returns the
//            expected output for a gate type and inputs, and whether the
//            gate type code is a real gate.
// Revision : 1.0 - initial release
// ============================================================================
module gate_expect
   import gate_pkg::*;
(
   input  logic [2:0] sel,
   input  logic       a,
   input  logic       b,
   output logic       expected,
   output logic       valid
);

   // Truth-table lookup for the selected gate type.
   always_comb begin
      expected = 1'b0;
      valid    = 1'b1;
      case (sel)
         GATE_AND:  expected = a & b;
         GATE_OR:   expected = a | b;
         GATE_NAND: expected = ~(a & b);
         GATE_NOR:  expected = ~(a | b);
         GATE_XOR:  expected = a ^ b;
         GATE_XNOR: expected = ~(a ^ b);
         default:   valid    = 1'b0;
      endcase
   end

endmodule : gate_expect
`default_nettype wire

// File: rtl/gate_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_checker
// Purpose  : Drives the four-vector truth table onto a two-input gate, waits
//            a programmable settle time per vector, samples the gate output
//            and reports pass flag, mismatch count and per-vector fail mask.
// Revision : 1.0 - initial release
// ============================================================================
module gate_checker
   import gate_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
)(
   input  logic         clk,
   input  logic         rst,
   gate_checker_if.slave bus
);

   localparam logic [3:0] c_settle   = 4'(SETTLE_CYCLES);
   localparam logic [1:0] c_last_idx = 2'(NUM_VECTORS - 1);

   logic [1:0] r_state;
   logic [1:0] w_state_next;
   logic [2:0] r_sel;
   logic [1:0] r_idx;
   logic [3:0] r_cnt;
   logic       r_a;
   logic       r_b;
   logic       r_pass;
   logic [2:0] r_err_cnt;
   logic [3:0] r_fail_mask;

   logic [2:0] w_model_sel;
   logic       w_expected;
   logic       w_sel_valid;
   logic       w_mismatch;
   logic [3:0] w_fail_mask_next;
   logic [1:0] w_idx_next;
   logic       w_busy;
   logic       w_done;

   // In IDLE the model only qualifies the incoming selection; afterwards it
   // supplies the expected value for the latched gate type.
   assign w_model_sel = (r_state == ST_IDLE) ? bus.gate_sel : r_sel;

   gate_expect u_expect (
      .sel      (w_model_sel),
      .a        (r_a),
      .b        (r_b),
      .expected (w_expected),
      .valid    (w_sel_valid)
   );

   // Only an exact match clears the mismatch flag, so an unknown X is a fail.
   always_comb begin
      w_mismatch = 1'b1;
      if (bus.x == w_expected) begin
         w_mismatch = 1'b0;
      end
   end

   assign w_fail_mask_next = r_fail_mask | ({3'b000, w_mismatch} << r_idx);
   assign w_idx_next       = r_idx + 2'd1;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: settle phase is skipped entirely when SETTLE_CYCLES=0.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               if (!w_sel_valid) begin
                  w_state_next = ST_DONE;
               end else if (c_settle == 4'd0) begin
                  w_state_next = ST_SAMPLE;
               end else begin
                  w_state_next = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (r_cnt <= 4'd1) begin
               w_state_next = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (r_idx == c_last_idx) begin
               w_state_next = ST_DONE;
            end else if (c_settle == 4'd0) begin
               w_state_next = ST_SAMPLE;
            end else begin
               w_state_next = ST_SETTLE;
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the state register.
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         ST_SETTLE, ST_SAMPLE: w_busy = 1'b1;
         ST_DONE:              w_done = 1'b1;
         default: ;
      endcase
   end

   // Stimulus, settle counter, vector index and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel       <= 3'd0;
         r_idx       <= 2'd0;
         r_cnt       <= 4'd0;
         r_a         <= 1'b0;
         r_b         <= 1'b0;
         r_pass      <= 1'b0;
         r_err_cnt   <= 3'd0;
         r_fail_mask <= 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_sel <= bus.gate_sel;
                  r_idx <= 2'd0;
                  r_cnt <= c_settle;
                  r_a   <= 1'b0;
                  r_b   <= 1'b0;
                  r_pass <= 1'b0;
                  if (w_sel_valid) begin
                     r_err_cnt   <= 3'd0;
                     r_fail_mask <= 4'h0;
                  end else begin
                     // Unknown gate type: report every vector as failed.
                     r_err_cnt   <= 3'(NUM_VECTORS);
                     r_fail_mask <= 4'hF;
                  end
               end
            end
            ST_SETTLE: begin
               r_cnt <= r_cnt - 4'd1;
            end
            ST_SAMPLE: begin
               r_fail_mask <= w_fail_mask_next;
               r_err_cnt   <= r_err_cnt + {2'b00, w_mismatch};
               if (r_idx == c_last_idx) begin
                  r_a    <= 1'b0;
                  r_b    <= 1'b0;
                  r_pass <= (w_fail_mask_next == 4'h0);
               end else begin
                  r_idx <= w_idx_next;
                  r_a   <= w_idx_next[0];
                  r_b   <= w_idx_next[1];
                  r_cnt <= c_settle;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.a         = r_a;
   assign bus.b         = r_b;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.pass      = r_pass;
   assign bus.err_cnt   = r_err_cnt;
   assign bus.fail_mask = r_fail_mask;

endmodule : gate_checker
`default_nettype wire

// File: tb/tb_gate_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_checker
// Purpose  : Directed bench for gate_checker: a table of sweeps against a
//            modelled gate on a SETTLE_CYCLES=2 instance, plus hand-written
//            sequences for the zero-settle, ignored-start and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_checker;

   typedef struct {
      logic [2:0] sel;
      int         gut;
      logic       exp_pass;
      logic [2:0] exp_err;
      logic [3:0] exp_mask;
      int         done_edge;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   gut0 = 0;
   int   gut1 = 5;
   int   n_checks = 0;
   int   n_errors = 0;
   vec_t tbl[9];

   gate_checker_if bus0 ();
   gate_checker_if bus1 ();

   gate_checker #(.SETTLE_CYCLES(2)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   gate_checker #(.SETTLE_CYCLES(0)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   always #5 clk = ~clk;

   // Gate under test attached to each checker (0 AND .. 5 XNOR).
   function automatic logic gate_fn(input int g, input logic a, input logic b);
      case (g)
         0:       return a & b;
         1:       return a | b;
         2:       return ~(a & b);
         3:       return ~(a | b);
         4:       return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   always_comb bus0.x = gate_fn(gut0, bus0.a, bus0.b);
   always_comb bus1.x = gate_fn(gut1, bus1.a, bus1.b);

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One full sweep on the SETTLE_CYCLES=2 instance, checked every cycle.
   task automatic run_sweep0(input vec_t v);
      int vi;
      @(negedge clk);
      gut0          = v.gut;
      bus0.gate_sel = v.sel;
      bus0.start    = 1'b1;
      for (int k = 0; k <= v.done_edge + 1; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) bus0.start = 1'b0;
         check("busy", int'(bus0.busy), int'(k < v.done_edge));
         check("done", int'(bus0.done), int'(k == v.done_edge));
         if (k < v.done_edge && (k % 3) == 0) begin
            vi = k / 3;
            check("vec_a", int'(bus0.a), vi & 1);
            check("vec_b", int'(bus0.b), (vi >> 1) & 1);
         end
         if (k == v.done_edge) begin
            check("pass", int'(bus0.pass), int'(v.exp_pass));
            check("err_cnt", int'(bus0.err_cnt), int'(v.exp_err));
            check("fail_mask", int'(bus0.fail_mask), int'(v.exp_mask));
            check("done_a", int'(bus0.a), 0);
            check("done_b", int'(bus0.b), 0);
         end
      end
      // Results stay held in IDLE.
      check("held_pass", int'(bus0.pass), int'(v.exp_pass));
      check("held_mask", int'(bus0.fail_mask), int'(v.exp_mask));
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached, expected $finish earlier");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen_done;
      tbl[0] = '{3'd5, 5, 1'b1, 3'd0, 4'h0, 12};  // XNOR vs xnor gate
      tbl[1] = '{3'd4, 5, 1'b0, 3'd4, 4'hF, 12};  // XOR vs xnor gate
      tbl[2] = '{3'd0, 1, 1'b0, 3'd2, 4'h6, 12};  // AND vs or gate
      tbl[3] = '{3'd1, 1, 1'b1, 3'd0, 4'h0, 12};  // OR vs or gate
      tbl[4] = '{3'd2, 0, 1'b0, 3'd4, 4'hF, 12};  // NAND vs and gate
      tbl[5] = '{3'd4, 0, 1'b0, 3'd3, 4'hE, 12};  // XOR vs and gate
      tbl[6] = '{3'd3, 3, 1'b1, 3'd0, 4'h0, 12};  // NOR vs nor gate
      tbl[7] = '{3'd7, 5, 1'b0, 3'd4, 4'hF, 0};   // invalid select
      tbl[8] = '{3'd6, 0, 1'b0, 3'd4, 4'hF, 0};   // invalid select

      bus0.start = 1'b0; bus0.gate_sel = 3'd0;
      bus1.start = 1'b0; bus1.gate_sel = 3'd0;

      // Reset state of both instances.
      repeat (3) @(posedge clk);
      #1;
      check("rst_a", int'(bus0.a), 0);
      check("rst_b", int'(bus0.b), 0);
      check("rst_busy", int'(bus0.busy), 0);
      check("rst_done", int'(bus0.done), 0);
      check("rst_pass", int'(bus0.pass), 0);
      check("rst_err", int'(bus0.err_cnt), 0);
      check("rst_mask", int'(bus0.fail_mask), 0);
      check("rst1_busy", int'(bus1.busy), 0);
      check("rst1_mask", int'(bus1.fail_mask), 0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven sweeps.
      for (int t = 0; t < 9; t++) begin
         run_sweep0(tbl[t]);
      end

      // Zero settle time, START held high through and past the sweep.
      @(negedge clk);
      bus1.gate_sel = 3'd5;
      bus1.start    = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         @(posedge clk);
         #1;
         check("s0_busy", int'(bus1.busy), int'(k < 4));
         check("s0_done", int'(bus1.done), int'(k == 4));
         if (k < 4) begin
            check("s0_a", int'(bus1.a), k & 1);
            check("s0_b", int'(bus1.b), (k >> 1) & 1);
         end
      end
      check("s0_pass", int'(bus1.pass), 1);
      check("s0_err", int'(bus1.err_cnt), 0);
      check("s0_mask", int'(bus1.fail_mask), 0);
      // START during the DONE cycle is ignored.
      @(posedge clk);
      #1;
      check("s0_done_start_busy", int'(bus1.busy), 0);
      check("s0_done_start_done", int'(bus1.done), 0);
      // First IDLE cycle accepts the still-high START.
      @(posedge clk);
      #1;
      check("s0_b2b_busy", int'(bus1.busy), 1);
      check("s0_b2b_pass_clr", int'(bus1.pass), 0);
      bus1.start = 1'b0;
      for (int k = 7; k <= 10; k++) begin
         @(posedge clk);
         #1;
         check("s0_b2b_done", int'(bus1.done), int'(k == 10));
      end
      check("s0_b2b_pass", int'(bus1.pass), 1);

      // Reset in the middle of a sweep.
      @(negedge clk);
      gut0          = 0;
      bus0.gate_sel = 3'd0;
      bus0.start    = 1'b1;
      @(posedge clk);
      #1;
      bus0.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_a_before_rst", int'(bus0.a), 1);
      check("mid_busy_before_rst", int'(bus0.busy), 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_a", int'(bus0.a), 0);
      check("mid_rst_busy", int'(bus0.busy), 0);
      check("mid_rst_done", int'(bus0.done), 0);
      check("mid_rst_pass", int'(bus0.pass), 0);
      check("mid_rst_err", int'(bus0.err_cnt), 0);
      check("mid_rst_mask", int'(bus0.fail_mask), 0);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         #1;
         if (bus0.done || bus0.busy) seen_done = 1'b1;
      end
      check("mid_no_done_after_rst", int'(seen_done), 0);
      run_sweep0(tbl[2]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_gate_checker
`default_nettype wire
